// File: rtl/invert_arbiter_pkg.sv
// Shared types and the round-robin search used by the invert_arbiter block.
package invert_arbiter_pkg;

  localparam int unsigned MAX_N   = 16;
  localparam int unsigned MAX_IDW = 4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } rr_pick_t;

  // First set bit of valid[n-1:0], searching from ptr upward and wrapping at n.
  // Sized for the largest legal N; callers zero-extend their vectors.
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0]   valid,
                                       input logic [MAX_IDW-1:0] ptr,
                                       input int unsigned        n);
    rr_pick_t         res;
    logic [MAX_IDW:0] cand;
    res = '0;
    for (int k = 0; k < MAX_N; k++) begin
      if ((k < int'(n)) && !res.found) begin
        cand = {1'b0, ptr} + (MAX_IDW+1)'(k);
        if (cand >= (MAX_IDW+1)'(n)) cand = cand - (MAX_IDW+1)'(n);
        if (valid[cand[MAX_IDW-1:0]]) begin
          res.found = 1'b1;
          res.idx   = cand[MAX_IDW-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/invert_arbiter_rr_grant.sv
// Combinational round-robin picker: lowest-distance valid requester from ptr.
module rr_grant
  import invert_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] ptr,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_idx
);

  rr_pick_t pick;

  // Widen to the package search width, pick, then narrow back to IDW.
  always_comb begin
    pick      = rr_pick(MAX_N'(valid), MAX_IDW'(ptr), N);
    gnt_valid = pick.found;
    gnt_idx   = pick.idx[IDW-1:0];
  end

endmodule

// File: rtl/invert_arbiter.sv
// Round-robin arbiter in front of a shared W-bit inverter with one output slot.
module invert_arbiter
  import invert_arbiter_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int W   = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [IDW-1:0] out_id,
  input  logic           out_ready
);

  slot_state_e    state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [W-1:0]   data_q;
  logic [IDW-1:0] id_q;

  logic           gnt_valid;
  logic [IDW-1:0] gnt_idx;
  logic           can_accept;
  logic           xfer;
  logic [W-1:0]   sel_word;

  rr_grant #(.N(N), .IDW(IDW)) u_rr_grant (
    .valid     (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Ready fan-out to the granted requester; suppressed while in reset so no
  // handshake completes on a reset edge.
  always_comb begin
    can_accept = (state_q == SLOT_EMPTY) || out_ready;
    in_ready   = '0;
    if (!rst && can_accept && gnt_valid) in_ready[gnt_idx] = 1'b1;
    xfer       = |in_ready;
    sel_word   = in_data[gnt_idx*W +: W];
    ptr_d      = (gnt_idx == IDW'(N-1)) ? '0 : gnt_idx + 1'b1;
  end

  // Slot FSM, pointer and registered result; a drain and a fill in the same
  // cycle keep the slot FULL with the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else if (xfer) begin
      state_q <= SLOT_FULL;
      data_q  <= ~sel_word;
      id_q    <= gnt_idx;
      ptr_q   <= ptr_d;
    end else if (out_ready) begin
      state_q <= SLOT_EMPTY;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;

endmodule
